// File: rtl/ps2_capture_sequencer_if.sv
// Signal bundle between the PS/2 byte receiver/consumer side and the capture sequencer.
// The master side drives requests and bytes, and the slave side (the sequencer) drives status and the assembled word.
interface ps2_capture_sequencer_if;
    logic        start;
    logic        byteValid;
    logic [7:0]  byteIn;
    logic        ack;
    logic [2:0]  estado;
    logic [3:0]  regEn;
    logic [31:0] data;
    logic        busy;
    logic        done;
    logic        timeoutErr;

    modport master (
        output start, byteValid, byteIn, ack,
        input  estado, regEn, data, busy, done, timeoutErr
    );

    modport slave (
        input  start, byteValid, byteIn, ack,
        output estado, regEn, data, busy, done, timeoutErr
    );
endinterface

// File: rtl/ps2_capture_sequencer.sv
// Collects four PS/2 bytes into a 32-bit word, one lane per capture state, and drives
// the 3-bit estado code for the register-enable decoder. An inter-byte timeout aborts a stalled capture into ERR.
module ps2_capture_sequencer #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    ps2_capture_sequencer_if.slave   bus
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE = 3'b000,
        CAP0 = 3'b001,
        CAP1 = 3'b010,
        CAP2 = 3'b011,
        CAP3 = 3'b100,
        DONE = 3'b101,
        ERR  = 3'b110
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   data_q, data_d;
    logic [3:0]    regEn_q, regEn_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [1:0]    lane;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        regEn_d = '0;
        lane    = '0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = CAP0;
                    cnt_d   = '0;
                    data_d  = '0;
                end
            end
            CAP0, CAP1, CAP2, CAP3: begin
                // Capture codes are consecutive, so the lane is the code minus one and CAP3+1 lands on DONE.
                lane = 2'(state_q - 3'd1);
                if (bus.byteValid) begin
                    data_d[{lane, 3'b000} +: 8] = bus.byteIn;
                    regEn_d = 4'b0001 << lane;
                    cnt_d   = '0;
                    state_d = state_e'(state_q + 3'd1);
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ERR;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE, ERR: begin
                if (bus.ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == CAP0) || (state_d == CAP1) ||
                 (state_d == CAP2) || (state_d == CAP3);
        done_d = (state_d == DONE);
        err_d  = (state_d == ERR);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            regEn_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            regEn_q <= regEn_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign bus.estado     = state_q;
    assign bus.regEn      = regEn_q;
    assign bus.data       = data_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.timeoutErr = err_q;

endmodule

// File: tb/tb_ps2_capture_sequencer.sv
// Directed and randomized bench for ps2_capture_sequencer, checked cycle by cycle
// against a byte-list reference model of the capture sequence.
module tb_ps2_capture_sequencer;

    localparam int TIMEOUT = 8;

    logic clk_i = 1'b0;
    logic rst_i;
    int   checkCount = 0;
    int   failCount  = 0;

    always #5 clk_i = ~clk_i;

    ps2_capture_sequencer_if bus();

    ps2_capture_sequencer #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus.slave)
    );

    // Model phase: 0 idle, 1..4 waiting for byte phase-1, 5 done, 6 timed out.
    int          mPhase = 0;
    int          mWait  = 0;
    logic [31:0] mData  = '0;
    logic [3:0]  mRegEn = '0;

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic modelStep(input logic r, input logic s, input logic bv,
                             input logic [7:0] b, input logic a);
        mRegEn = '0;
        if (r) begin
            mPhase = 0;
            mWait  = 0;
            mData  = '0;
        end else if (mPhase == 0) begin
            if (s) begin
                mPhase = 1;
                mWait  = 0;
                mData  = '0;
            end
        end else if (mPhase <= 4) begin
            if (bv) begin
                mData[8*(mPhase-1) +: 8] = b;
                mRegEn = 4'(1 << (mPhase - 1));
                mWait  = 0;
                mPhase = mPhase + 1;
            end else if (mWait == TIMEOUT - 1) begin
                mPhase = 6;
            end else begin
                mWait++;
            end
        end else if (a) begin
            mPhase = 0;
        end
    endtask

    task automatic applyStimulus(input logic r, input logic s, input logic bv,
                                 input logic [7:0] b, input logic a);
        rst_i         = r;
        bus.start     = s;
        bus.byteValid = bv;
        bus.byteIn    = b;
        bus.ack       = a;
        @(posedge clk_i);
        modelStep(r, s, bv, b, a);
        #1;
        checkOutput("estado", 32'(bus.estado), 32'(mPhase));
        checkOutput("regEn", 32'(bus.regEn), 32'(mRegEn));
        checkOutput("data", bus.data, mData);
        checkOutput("busy", 32'(bus.busy), 32'(mPhase >= 1 && mPhase <= 4));
        checkOutput("done", 32'(bus.done), 32'(mPhase == 5));
        checkOutput("timeoutErr", 32'(bus.timeoutErr), 32'(mPhase == 6));
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic sendByte(input logic [7:0] b);
        applyStimulus(1'b0, 1'b0, 1'b1, b, 1'b0);
    endtask

    initial begin
        logic [7:0] normalBytes [4];
        int         bvDiv;
        logic       r, s, bv, a;
        logic [7:0] b;

        normalBytes = '{8'h1C, 8'hF0, 8'h1C, 8'h5A};

        // Reset, then activity, then a one-cycle reset pulse.
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        checkOutput("resetEstado", 32'(bus.estado), 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        sendByte(8'h77);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        checkOutput("resetData", bus.data, 32'h0);
        idleCycles(2);

        $display("[TB] normal capture");
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        checkOutput("startEstado", 32'(bus.estado), 32'h1);
        for (int i = 0; i < 4; i++) begin
            idleCycles(2);
            sendByte(normalBytes[i]);
            checkOutput("normalRegEn", 32'(bus.regEn), 32'(4'b0001 << i));
        end
        checkOutput("normalData", bus.data, 32'h5A1CF01C);
        idleCycles(3);
        checkOutput("normalDoneHeld", 32'(bus.done), 32'h1);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        idleCycles(1);

        $display("[TB] back-to-back capture");
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        sendByte(8'h11);
        sendByte(8'h22);
        sendByte(8'h33);
        sendByte(8'h44);
        checkOutput("b2bDone", 32'(bus.done), 32'h1);
        checkOutput("b2bData", bus.data, 32'h44332211);
        applyStimulus(1'b0, 1'b1, 1'b1, 8'hFF, 1'b0);
        checkOutput("doneIgnoresByte", bus.data, 32'h44332211);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
        checkOutput("ackStartIdle", 32'(bus.estado), 32'h0);
        idleCycles(1);
        checkOutput("startNotLatched", 32'(bus.estado), 32'h0);

        $display("[TB] timeout");
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        sendByte(8'hAA);
        idleCycles(TIMEOUT - 1);
        checkOutput("preTimeoutEstado", 32'(bus.estado), 32'h2);
        idleCycles(1);
        checkOutput("timeoutEstado", 32'(bus.estado), 32'h6);
        checkOutput("timeoutErrFlag", 32'(bus.timeoutErr), 32'h1);
        checkOutput("timeoutData", bus.data, 32'h000000AA);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        checkOutput("timeoutAckIdle", 32'(bus.estado), 32'h0);

        $display("[TB] byte on expiring cycle");
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        sendByte(8'h01);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        checkOutput("startInCap1", 32'(bus.estado), 32'h2);
        sendByte(8'h02);
        idleCycles(TIMEOUT - 1);
        sendByte(8'h03);
        checkOutput("expiryByteEstado", 32'(bus.estado), 32'h4);
        checkOutput("expiryByteNoErr", 32'(bus.timeoutErr), 32'h0);
        sendByte(8'h04);
        checkOutput("expiryData", bus.data, 32'h04030201);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);

        $display("[TB] reset mid-capture");
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        sendByte(8'hDE);
        sendByte(8'hAD);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        checkOutput("midResetEstado", 32'(bus.estado), 32'h0);
        checkOutput("midResetData", bus.data, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        sendByte(8'hBE);
        sendByte(8'hEF);
        sendByte(8'h12);
        sendByte(8'h34);
        checkOutput("afterResetData", bus.data, 32'h3412EFBE);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);

        $display("[TB] randomized traffic");
        for (int seg = 0; seg < 15; seg++) begin
            case ($urandom_range(0, 2))
                0:       bvDiv = 0;
                1:       bvDiv = 3;
                default: bvDiv = 12;
            endcase
            for (int i = 0; i < 200; i++) begin
                r  = ($urandom_range(0, 199) == 0);
                s  = ($urandom_range(0, 5) == 0);
                bv = ($urandom_range(0, bvDiv) == 0);
                b  = 8'($urandom);
                a  = ($urandom_range(0, 4) == 0);
                applyStimulus(r, s, bv, b, a);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
